// File: rtl/uart_pkg.sv
// Shared definitions for the RS-232 UART blocks: receiver FSM states,
// oversampling ratio, baud divider computation and the majority vote.
package uart_pkg;

    // Samples taken per bit period by the receiver.
    localparam int OVERSAMPLE = 16;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Clock cycles per oversample tick (or per bit when oversample=1),
    // integer-truncated. Shared with baud_generator so both ends divide alike.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

    // Two-out-of-three vote used for the mid-bit decision.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick generator: free-running 0..DIV-1 counter that pulses tick
// for one cycle at wrap. A synchronous clear re-phases it to a start edge.
module rx_tick_gen #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter; clear restarts the count so ticks align to the edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/byte_receiver.sv
// RS-232 8N1 receiver: 2-flop input synchronizer, 16x oversampling with a
// 3-sample majority vote at mid-bit, and a single-entry holding register
// with acknowledge, overrun and framing-error reporting.
module byte_receiver #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       overrun,
    output logic       frame_err
);

    import uart_pkg::*;

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);

    // Sample-counter values (after the increment) that capture the vote.
    localparam logic [3:0] VOTE_A = 4'd6;
    localparam logic [3:0] VOTE_B = 4'd7;
    localparam logic [3:0] DECIDE = 4'd8;

    logic       rx_meta;
    logic       rxs;
    logic       rxs_d;
    logic       start_edge;

    logic       tick;
    logic       clear_tick;
    logic [3:0] samp_cnt;
    logic [3:0] samp_inc;
    logic       vote_a;
    logic       vote_b;
    logic       decide;
    logic       bit_val;

    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic       shift_en;
    logic       load_byte;
    logic       frame_set;

    rx_state_t  state;
    rx_state_t  state_next;

    // Synchronize the asynchronous line; flops reset to the idle level so a
    // reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rs232_rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign start_edge = rxs_d & ~rxs;

    rx_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_tick),
        .tick  (tick)
    );

    assign samp_inc = samp_cnt + 4'd1;
    assign decide   = tick && (samp_inc == DECIDE);
    assign bit_val  = majority3(vote_a, vote_b, rxs);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes.
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        clear_tick = 1'b0;
        shift_en   = 1'b0;
        load_byte  = 1'b0;
        frame_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    clear_tick = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (decide) begin
                    state_next = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (decide) begin
                    if (bit_val) begin
                        load_byte  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample counter, vote captures, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt  <= '0;
            vote_a    <= 1'b1;
            vote_b    <= 1'b1;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (clear_tick) begin
                samp_cnt <= '0;
                bit_idx  <= '0;
            end else if (tick) begin
                samp_cnt <= samp_inc;
                if (samp_inc == VOTE_A) begin
                    vote_a <= rxs;
                end
                if (samp_inc == VOTE_B) begin
                    vote_b <= rxs;
                end
            end
            if (shift_en) begin
                shift_reg <= {bit_val, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

    // Holding register and flags; a byte load takes priority over rx_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte   <= '0;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_set;
            if (load_byte) begin
                rx_byte  <= shift_reg;
                rx_ready <= 1'b1;
                overrun  <= rx_ack ? 1'b0 : (overrun | rx_ready);
            end else if (rx_ack) begin
                rx_ready <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule
